// File: rtl/rnd_serve.sv
// Bounded serve-position generator: rejection-samples the free-running LFSR word
// at STRIDE-cycle spacing and falls back to mid-field after MAX_TRIES misses.
module rnd_serve #(
  parameter int RND_W     = 16,
  parameter int Y_W       = 10,
  parameter int Y_MIN     = 16,
  parameter int Y_MAX     = 463,
  parameter int STRIDE    = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [RND_W-1:0] rnd_num_i,
  input  logic             serve_req_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [Y_W-1:0]   ball_y_o,
  output logic             dir_x_o,
  output logic             dir_y_o,
  output logic             fallback_o
);

  localparam int SC_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int TR_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [SC_W-1:0] STRIDE_LAST = SC_W'(STRIDE - 1);
  localparam logic [TR_W-1:0] TRIES_LAST  = TR_W'(MAX_TRIES - 1);
  localparam logic [Y_W-1:0]  Y_LO        = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0]  Y_HI        = Y_W'(Y_MAX);
  // Midpoint sum carries one extra bit so it cannot overflow before the halving.
  localparam logic [Y_W:0]    MID_SUM     = {1'b0, Y_LO} + {1'b0, Y_HI};
  localparam logic [Y_W-1:0]  Y_MID       = MID_SUM[Y_W:1];

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SAMPLE = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [SC_W-1:0] stride_r, stride_s, stride_wrap_s;
  logic [TR_W-1:0] tries_r, tries_s;
  logic [Y_W-1:0]  cand_s;
  logic            in_range_s;
  logic            load_s;
  logic            fb_s;
  logic            unused_s;

  // Only the low Y_W bits and the top two bits of the LFSR word carry meaning.
  assign unused_s = ^rnd_num_i;

  // Candidate extraction, range test and stride wrap
  always_comb begin
    cand_s     = rnd_num_i[Y_W-1:0];
    in_range_s = (cand_s >= Y_LO) && (cand_s <= Y_HI);
    if (stride_r == STRIDE_LAST) begin
      stride_wrap_s = '0;
    end else begin
      stride_wrap_s = stride_r + SC_W'(1);
    end
  end

  // Next-state, counter and result-load decode
  always_comb begin
    state_s  = state_r;
    stride_s = stride_r;
    tries_s  = tries_r;
    load_s   = 1'b0;
    fb_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (serve_req_i) begin
          state_s  = ST_SAMPLE;
          stride_s = '0;
          tries_s  = '0;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        stride_s = stride_wrap_s;
        if (stride_r == '0) begin
          if (in_range_s) begin
            load_s  = 1'b1;
            state_s = ST_IDLE;
          end else if (tries_r == TRIES_LAST) begin
            load_s  = 1'b1;
            fb_s    = 1'b1;
            state_s = ST_IDLE;
          end else begin
            tries_s = tries_r + TR_W'(1);
          end
        end else begin
          tries_s = tries_r;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        stride_s = '0;
        tries_s  = '0;
      end
    endcase
  end

  // FSM state and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      stride_r <= '0;
      tries_r  <= '0;
    end else begin
      state_r  <= state_s;
      stride_r <= stride_s;
      tries_r  <= tries_s;
    end
  end

  // Registered outputs; result fields only move when a result is loaded
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o     <= 1'b0;
      valid_o    <= 1'b0;
      ball_y_o   <= '0;
      dir_x_o    <= 1'b0;
      dir_y_o    <= 1'b0;
      fallback_o <= 1'b0;
    end else begin
      busy_o  <= (state_s == ST_SAMPLE);
      valid_o <= load_s;
      if (load_s) begin
        ball_y_o   <= fb_s ? Y_MID : cand_s;
        dir_x_o    <= rnd_num_i[RND_W-1];
        dir_y_o    <= rnd_num_i[RND_W-2];
        fallback_o <= fb_s;
      end
    end
  end

endmodule

// File: tb/tb_rnd_serve.sv
// Directed self-checking bench for rnd_serve: latency, boundaries, fallback,
// busy/back-to-back request handling and mid-request reset.
module tb_rnd_serve;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] rnd_num_i;
  logic        serve_req_i;
  logic        busy_o;
  logic        valid_o;
  logic [9:0]  ball_y_o;
  logic        dir_x_o;
  logic        dir_y_o;
  logic        fallback_o;

  int n_pass  = 0;
  int n_total = 0;
  int lat;
  int nbusy;
  int seen;

  rnd_serve dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rnd_num_i   (rnd_num_i),
    .serve_req_i (serve_req_i),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .ball_y_o    (ball_y_o),
    .dir_x_o     (dir_x_o),
    .dir_y_o     (dir_y_o),
    .fallback_o  (fallback_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Request with v0 on the first sample, v1 from cycle N+2 onward; returns latency.
  task automatic do_serve(input logic [15:0] v0, input logic [15:0] v1,
                          output int l, output int nb);
    rnd_num_i   = v0;
    serve_req_i = 1'b1;
    tick();
    serve_req_i = 1'b0;
    l  = 1;
    nb = int'(busy_o);
    while (valid_o !== 1'b1 && l < 60) begin
      tick();
      l++;
      if (l == 2) rnd_num_i = v1;
      nb += int'(busy_o);
    end
  endtask

  task automatic check_result(input string tag, input int exp_lat, input int exp_y,
                              input logic dx, input logic dy, input logic fb);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_y"}, 32'(ball_y_o), exp_y);
    check({tag, "_dir"}, {30'd0, dir_x_o, dir_y_o}, {30'd0, dx, dy});
    check({tag, "_fb"}, 32'(fallback_o), 32'(fb));
    tick();
    check({tag, "_pulse"}, {30'd0, valid_o, busy_o}, 32'd0);
  endtask

  initial begin
    rst_i       = 1'b1;
    serve_req_i = 1'b0;
    rnd_num_i   = 16'h0000;
    repeat (3) tick();
    rst_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_outs", {16'd0, valid_o, busy_o, dir_x_o, dir_y_o, fallback_o, ball_y_o, 1'b0},
            32'd0);
    end

    do_serve(16'h80C8, 16'h80C8, lat, nbusy);
    check_result("basic200", 2, 200, 1'b1, 1'b0, 1'b0);

    do_serve(16'hC010, 16'h0000, lat, nbusy);
    check_result("min16", 2, 16, 1'b1, 1'b1, 1'b0);

    do_serve(16'h41CF, 16'h0000, lat, nbusy);
    check_result("max463", 2, 463, 1'b0, 1'b1, 1'b0);

    do_serve(16'h000F, 16'h412C, lat, nbusy);
    check_result("rej15", 6, 300, 1'b0, 1'b1, 1'b0);

    do_serve(16'h01D0, 16'h812C, lat, nbusy);
    check_result("rej464", 6, 300, 1'b1, 1'b0, 1'b0);

    do_serve(16'hC3E8, 16'hC3E8, lat, nbusy);
    check("fallback_busy", nbusy, 29);
    check_result("fallback", 30, 239, 1'b1, 1'b1, 1'b1);

    // Request pulsed while busy must be ignored
    rnd_num_i   = 16'h03E8;
    serve_req_i = 1'b1;
    tick();
    serve_req_i = 1'b0;
    tick();
    serve_req_i = 1'b1;
    rnd_num_i   = 16'h812C;
    tick();
    serve_req_i = 1'b0;
    check("ign_busy", 32'(busy_o), 32'd1);
    tick();
    tick();
    check("ign_novalid", 32'(valid_o), 32'd0);
    tick();
    check("ign_valid", {21'd0, valid_o, ball_y_o}, {21'd0, 1'b1, 10'd300});
    tick();
    check("ign_noextra", {30'd0, valid_o, busy_o}, 32'd0);

    // Back-to-back: request in the valid_o cycle
    do_serve(16'h00C8, 16'h00C8, lat, nbusy);
    check("b2b_first", {21'd0, valid_o, ball_y_o}, {21'd0, 1'b1, 10'd200});
    serve_req_i = 1'b1;
    rnd_num_i   = 16'h4064;
    tick();
    serve_req_i = 1'b0;
    check("b2b_mid", {30'd0, valid_o, busy_o}, {30'd0, 1'b0, 1'b1});
    tick();
    check("b2b_second", {20'd0, valid_o, ball_y_o, dir_y_o}, {20'd0, 1'b1, 10'd100, 1'b1});

    // Reset in the third SAMPLE cycle aborts the request
    tick();
    rnd_num_i   = 16'h03E8;
    serve_req_i = 1'b1;
    tick();
    serve_req_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_outs", {16'd0, valid_o, busy_o, dir_x_o, dir_y_o, fallback_o, ball_y_o, 1'b0},
          32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen += int'(valid_o) + int'(busy_o);
    end
    check("rst_quiet", seen, 0);

    do_serve(16'h80C8, 16'h80C8, lat, nbusy);
    check_result("recover", 2, 200, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
